// File: rtl/ev_sequencer.sv
// ev_sequencer: steps one execution event vector (EV) through a combinational
// operation stage, one instruction slot per clock, then hands the finished EV
// downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A producer keeps valid and data stable until that edge. This
// block keeps out_valid/out_ev stable until out_ready is seen. in_ready may
// depend on out_ready, but never on in_valid.
//
// Optional feature: define EV_SEQ_BYPASS_EN so that DONE can accept a new EV
// on the same edge that the finished EV leaves. With the macro undefined, the
// FSM always passes through IDLE between EVs.
module ev_sequencer #(
  parameter int EV_W      = 1024,
  parameter int OPC_LSB   = 512,
  parameter int INSTR_W   = 64,
  parameter int MAX_STEPS = 8,
  localparam int STEP_W   = $clog2(MAX_STEPS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EV_W-1:0]   in_ev,
  output logic [EV_W-1:0]   op_ev,
  input  logic [EV_W-1:0]   op_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EV_W-1:0]   out_ev,
  output logic              busy,
  output logic [STEP_W-1:0] step_count
);

  localparam int OPC_W = INSTR_W * MAX_STEPS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [EV_W-1:0]     ev_reg;
  logic [EV_W-1:0]     ev_nxt;
  logic [STEP_W-1:0]   step_nxt;
  logic [STEP_W-1:0]   step_inc;
  logic [EV_W-1:0]     shifted;
  logic [OPC_W-1:0]    opc_field;
  logic                accept;

  // Stage result with the program advanced by one slot (top slot zero-filled).
  always_comb begin
    opc_field = op_result[OPC_LSB +: OPC_W] >> INSTR_W;
    shifted   = op_result;
    shifted[OPC_LSB +: OPC_W] = opc_field;
  end

  assign step_inc = step_count + 1'b1;

  // Next-state, next-datapath and handshake decode.
  always_comb begin
    state_nxt = state;
    ev_nxt    = ev_reg;
    step_nxt  = step_count;
    in_ready  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
      end
      RUN: begin
        ev_nxt   = shifted;
        step_nxt = step_inc;
        if ((shifted[OPC_LSB +: 8] == 8'd0) || (step_inc == STEP_W'(MAX_STEPS))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
`ifdef EV_SEQ_BYPASS_EN
        in_ready = out_ready;
        accept   = out_ready && in_valid;
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A newly accepted EV overrides whatever the current state decided.
    if (accept) begin
      ev_nxt    = in_ev;
      step_nxt  = '0;
      state_nxt = (in_ev[OPC_LSB +: 8] != 8'd0) ? RUN : DONE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // EV and step counter registers; reset discards any in-flight EV.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_reg     <= '0;
      step_count <= '0;
    end else begin
      ev_reg     <= ev_nxt;
      step_count <= step_nxt;
    end
  end

  // The registered EV feeds both the operation stage and the output.
  assign op_ev     = ev_reg;
  assign out_ev    = ev_reg;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

endmodule

// File: doc/ev_sequencer.md
# ev_sequencer

Multi-cycle sequencer that sits directly upstream of the combinational operation stages, such as conditional increment, that transform an execution event vector (EV). It accepts one EV carrying a packed program of instruction slots and presents the EV to the operation stage once per clock. Each cycle it registers the stage's result with the opcode field advanced by one slot, until an end slot or the step limit is reached. It then hands the finished EV downstream over a valid/ready handshake.

## Interface
Parameters:
- `EV_W`, 1024: total EV width in bits.
- `OPC_LSB`, 512: bit position of slot 0 inside the EV.
- `INSTR_W`, 64: width of one instruction slot; bits [7:0] of a slot are the opcode selector.
- `MAX_STEPS`, 8: number of slots; the opcode field is `INSTR_W*MAX_STEPS` bits starting at `OPC_LSB`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: upstream EV valid.
- `in_ready`, output, 1: sequencer can accept an EV.
- `in_ev`, input, EV_W: incoming EV.
- `op_ev`, output, EV_W: EV driven to the operation stage.
- `op_result`, input, EV_W: combinational result returned by the operation stage.
- `out_valid`, output, 1: finished EV available.
- `out_ready`, input, 1: downstream accepts the EV.
- `out_ev`, output, EV_W: finished EV.
- `busy`, output, 1: high in RUN.
- `step_count`, output, $clog2(MAX_STEPS+1): number of slots executed for the current EV.

## Operation
- State machine with three states: IDLE, RUN, DONE. Registered `ev_reg`, `step_count`.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `ev_reg`<=`in_ev`, `step_count`<=0.
  - Next state is RUN if slot-0 opcode byte ≠0. Otherwise next state is DONE (empty program).
- **RUN**
  - `op_ev`=`ev_reg`.
  - Each edge: `ev_reg`<=`op_result` with the opcode field replaced by `op_result`'s opcode field >>`INSTR_W`, zero-filled at the top. All bits outside the opcode field come from `op_result` unchanged.
  - Each edge: `step_count`<=`step_count`+1.
  - Go to DONE when the post-shift slot-0 opcode byte is 0, or when `step_count`+1 == `MAX_STEPS`. Otherwise stay in RUN.
- **DONE**
  - `out_valid`=1, `out_ev`=`ev_reg`. `ev_reg` and `step_count` are held.
  - On `out_ready`: go to IDLE.
  - `in_ready`=0 in DONE unless the bypass feature is compiled in (see Configuration).
- Outside RUN, `op_ev`=`ev_reg`, so the operation stage sees stable data. `op_result` is ignored outside RUN.
- `out_ev` is held stable while `out_valid`=1 and `out_ready`=0.
- Upstream `in_valid` during RUN/DONE is ignored; `in_ready`=0 there, so no EV is lost.
- **Reset** (asynchronous, any state, including mid-RUN): state=IDLE, `ev_reg`=0, `step_count`=0, `in_ready`=1, `out_valid`=0, `busy`=0, `op_ev`=0, `out_ev`=0. The in-flight EV is discarded.

## Timing
- Accept edge E0.
- For a program of N non-zero slots (1≤N≤MAX_STEPS), RUN occupies the N cycles after E0. At edge EN the state becomes DONE, and `out_valid` is high in the cycle after EN. Total latency from accept to `out_valid` is N+1 edges.
- For an empty program (N=0), `out_valid` is high in the cycle after E0.
- Throughput without bypass is one EV per N+2 cycles minimum: accept, N RUN cycles, DONE, back to IDLE.
- The operation stage is purely combinational. Its `op_result` must settle within one cycle of `op_ev` changing.

## Configuration
- Macro `EV_SEQ_BYPASS_EN`:
  - **Defined:** in DONE, `in_ready`=`out_ready`. A simultaneous output handshake and input handshake loads `in_ev` in the same edge and goes directly to RUN (or back to DONE for an empty program), skipping IDLE. This gives one EV per N+1 cycles.
  - **Undefined:** `in_ready`=0 in DONE, and IDLE is always visited between EVs.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RUN at step 3 → next cycle IDLE, `in_ready`=1, `out_valid`=0, `step_count`=0, `out_ev`=0.
- **Empty program:** slot-0 opcode 0, word1=35 → `out_valid` one cycle after accept, `step_count`=0, `out_ev`==`in_ev`.
- **Countdown program:** five conditional-increment slots (reg3, A>B, i(0), i(-2), flag1), word3=10, conditional-increment stage attached → `out_valid` 6 edges after accept, word3=0, flag1=1, `step_count`=5, opcode field all zero.
- **Step limit:** all 8 slots non-zero (increment word1 by 1), word1=35 → DONE after 8 RUN cycles, word1=43, `step_count`=8.
- **Backpressure:** hold `out_ready`=0 for 4 cycles in DONE → `out_ev` stable, `in_ready`=0, and an upstream `in_valid` is not consumed. Release → IDLE, then the new EV is accepted.
- **Bypass** (with `EV_SEQ_BYPASS_EN` defined): `out_ready`=1 and `in_valid`=1 in the same DONE cycle → the second EV is accepted on that edge and `busy`=1 in the next cycle. Without the macro, `in_ready` stays 0 in that cycle.
